// File: rtl/gpt2_pkg.sv
// rtl/gpt2_pkg.sv - shared Q8.8 constants, table selectors and embedding FSM states
package gpt2_pkg;

  localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;

  localparam logic TBL_TOKEN = 1'b0;
  localparam logic TBL_POS   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT
  } emb_state_t;

  // Index width that stays legal for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/embedding_stream_unit_if.sv
// rtl/embedding_stream_unit_if.sv - table load, lookup request and beat stream bundle
interface embedding_stream_unit_if #(
  parameter int ROW_W      = 4,
  parameter int COL_W      = 3,
  parameter int TOK_W      = 4,
  parameter int POS_W      = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 2
);
  logic                         load_en;
  logic                         load_sel;
  logic [ROW_W-1:0]             load_row;
  logic [COL_W-1:0]             load_col;
  logic signed [DATA_WIDTH-1:0] load_data;

  logic                         in_valid;
  logic                         in_ready;
  logic [TOK_W-1:0]             token_id;
  logic                         pos_auto;
  logic [POS_W-1:0]             position;
  logic                         seq_clear;

  logic                         out_valid;
  logic                         out_ready;
  logic [LANES*DATA_WIDTH-1:0]  out_data;
  logic                         out_last;
  logic                         out_err;
  logic [POS_W-1:0]             pos_cnt;

  modport master (
    output load_en, load_sel, load_row, load_col, load_data,
    output in_valid, token_id, pos_auto, position, seq_clear, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_err, pos_cnt
  );

  modport slave (
    input  load_en, load_sel, load_row, load_col, load_data,
    input  in_valid, token_id, pos_auto, position, seq_clear, out_ready,
    output in_ready, out_valid, out_data, out_last, out_err, pos_cnt
  );
endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed adder with optional clamp to the signed range
module sat_add #(
  parameter int DATA_WIDTH = 16,
  parameter int SATURATE   = 1
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH:0] sum;

  assign sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

  // Overflow shows as disagreement between the guard bit and the result sign.
  always_comb begin
    y = sum[DATA_WIDTH-1:0];
    if ((SATURATE != 0) && (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]))
      y = sum[DATA_WIDTH] ? S_MIN : S_MAX;
  end
endmodule

// File: rtl/embedding_stream_unit.sv
// rtl/embedding_stream_unit.sv - token+position embedding lookup streamed in LANES-wide beats
module embedding_stream_unit
  import gpt2_pkg::*;
#(
  parameter int VOCAB_SIZE  = 16,
  parameter int MAX_SEQ_LEN = 8,
  parameter int EMBED_DIM   = 8,
  parameter int LANES       = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int SATURATE    = 1
) (
  input logic clk,
  input logic rst,
  embedding_stream_unit_if.slave es
);
  localparam int BEATS  = EMBED_DIM / LANES;
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int TOK_W  = clog2_min1(VOCAB_SIZE);
  localparam int POS_W  = clog2_min1(MAX_SEQ_LEN);
  localparam int TA_W   = clog2_min1(VOCAB_SIZE * BEATS);
  localparam int PA_W   = clog2_min1(MAX_SEQ_LEN * BEATS);

  emb_state_t                  state_q, state_d;
  logic [BEAT_W-1:0]           beat_q;
  logic [TOK_W-1:0]            tok_q;
  logic [POS_W-1:0]            pos_q, pos_cnt_q, eff_pos;
  logic                        err_q, auto_q, req_err;
  logic                        accept, beat_done, last_beat;
  logic [LANES*DATA_WIDTH-1:0] out_data_q, lane_sum;

  logic                        wr_tok, wr_pos;
  int                          wr_lane;
  logic [TA_W-1:0]             wr_tok_addr, rd_tok_addr;
  logic [PA_W-1:0]             wr_pos_addr, rd_pos_addr;

  // Each lane owns the elements whose column index maps to it, so one beat
  // is a single-address read across all lane memories.
  always_comb begin
    wr_lane     = int'(es.load_col) % LANES;
    wr_tok      = es.load_en && (es.load_sel == TBL_TOKEN) &&
                  (int'(es.load_row) < VOCAB_SIZE) && (int'(es.load_col) < EMBED_DIM);
    wr_pos      = es.load_en && (es.load_sel == TBL_POS) &&
                  (int'(es.load_row) < MAX_SEQ_LEN) && (int'(es.load_col) < EMBED_DIM);
    wr_tok_addr = TA_W'(int'(es.load_row) * BEATS + int'(es.load_col) / LANES);
    wr_pos_addr = PA_W'(int'(es.load_row) * BEATS + int'(es.load_col) / LANES);
    rd_tok_addr = err_q ? '0 : TA_W'(int'(tok_q) * BEATS + int'(beat_q));
    rd_pos_addr = err_q ? '0 : PA_W'(int'(pos_q) * BEATS + int'(beat_q));
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] tok_mem [VOCAB_SIZE*BEATS];
    logic signed [DATA_WIDTH-1:0] pos_mem [MAX_SEQ_LEN*BEATS];

    always_ff @(posedge clk) begin
      if (wr_tok && (wr_lane == k)) tok_mem[wr_tok_addr] <= es.load_data;
      if (wr_pos && (wr_lane == k)) pos_mem[wr_pos_addr] <= es.load_data;
    end

    sat_add #(.DATA_WIDTH(DATA_WIDTH), .SATURATE(SATURATE)) u_add (
      .a(tok_mem[rd_tok_addr]),
      .b(pos_mem[rd_pos_addr]),
      .y(lane_sum[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign es.in_ready = (state_q == IDLE) && !rst;
  assign accept      = es.in_valid && es.in_ready;
  assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_done   = (state_q == EMIT) && es.out_ready;
  assign eff_pos     = es.pos_auto ? (es.seq_clear ? '0 : pos_cnt_q) : es.position;
  assign req_err     = ({1'b0, es.token_id} >= (TOK_W+1)'(VOCAB_SIZE)) ||
                       (!es.pos_auto && ({1'b0, es.position} >= (POS_W+1)'(MAX_SEQ_LEN)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EMIT;
      EMIT:    if (es.out_ready) state_d = last_beat ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      tok_q      <= '0;
      pos_q      <= '0;
      err_q      <= 1'b0;
      auto_q     <= 1'b0;
      out_data_q <= '0;
      pos_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tok_q  <= es.token_id;
        pos_q  <= eff_pos;
        err_q  <= req_err;
        auto_q <= es.pos_auto;
        beat_q <= '0;
      end else if (beat_done && !last_beat) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
      if (state_q == READ) out_data_q <= err_q ? '0 : lane_sum;
      if (es.seq_clear)
        pos_cnt_q <= '0;
      else if (beat_done && last_beat && auto_q)
        pos_cnt_q <= (pos_cnt_q == POS_W'(MAX_SEQ_LEN - 1)) ? '0 : pos_cnt_q + POS_W'(1);
    end
  end

  assign es.out_valid = (state_q == EMIT);
  assign es.out_last  = (state_q == EMIT) && last_beat;
  assign es.out_err   = (state_q == EMIT) && err_q;
  assign es.out_data  = out_data_q;
  assign es.pos_cnt   = pos_cnt_q;
endmodule

// File: tb/tb_embedding_stream_unit.sv
// tb/tb_embedding_stream_unit.sv - directed scoreboard bench for embedding_stream_unit
module tb_embedding_stream_unit;
  import gpt2_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  beat_t       sb_a[$];
  logic [31:0] sb_b[$];
  logic [15:0] tok_m [16][8];
  logic [15:0] pos_m [8][8];
  logic [2:0]  pcnt_m = 3'd0;

  always #5 clk = ~clk;

  embedding_stream_unit_if #(.ROW_W(4), .COL_W(3), .TOK_W(4), .POS_W(3), .DATA_WIDTH(16), .LANES(2)) es_a ();
  embedding_stream_unit_if #(.ROW_W(4), .COL_W(3), .TOK_W(4), .POS_W(3), .DATA_WIDTH(16), .LANES(2)) es_b ();

  // Saturating unit with a 12-entry vocabulary; the wrapping unit runs in lockstep.
  embedding_stream_unit #(.VOCAB_SIZE(12), .MAX_SEQ_LEN(8), .EMBED_DIM(8), .LANES(2),
                          .DATA_WIDTH(16), .SATURATE(1)) dut_a (.clk(clk), .rst(rst), .es(es_a));
  embedding_stream_unit #(.VOCAB_SIZE(16), .MAX_SEQ_LEN(8), .EMBED_DIM(8), .LANES(2),
                          .DATA_WIDTH(16), .SATURATE(0)) dut_b (.clk(clk), .rst(rst), .es(es_b));

  assign es_b.load_en   = es_a.load_en;
  assign es_b.load_sel  = es_a.load_sel;
  assign es_b.load_row  = es_a.load_row;
  assign es_b.load_col  = es_a.load_col;
  assign es_b.load_data = es_a.load_data;
  assign es_b.in_valid  = es_a.in_valid;
  assign es_b.token_id  = es_a.token_id;
  assign es_b.pos_auto  = es_a.pos_auto;
  assign es_b.position  = es_a.position;
  assign es_b.seq_clear = es_a.seq_clear;
  assign es_b.out_ready = es_a.out_ready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_add(input logic [15:0] a, input logic [15:0] b, input bit sat);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (sat) begin
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
    end
    return s[15:0];
  endfunction

  task automatic load(input bit sel, input int row, input int col, input logic [15:0] d);
    es_a.load_en   = 1'b1;
    es_a.load_sel  = sel;
    es_a.load_row  = row[3:0];
    es_a.load_col  = col[2:0];
    es_a.load_data = d;
    tick();
    es_a.load_en = 1'b0;
    if (sel == TBL_TOKEN && row < 12) tok_m[row][col] = d;
    if (sel == TBL_POS && row < 8)    pos_m[row][col] = d;
  endtask

  task automatic request(input logic [3:0] tok, input bit auto_p, input logic [2:0] pos,
                         input bit clr, input bit push_b);
    int          g;
    logic [2:0]  p;
    bit          e;
    beat_t       x;
    logic [31:0] bd;
    g = 0;
    while (!es_a.in_ready && g < 50) begin
      tick();
      g++;
    end
    chk("req_ready", {31'd0, es_a.in_ready}, 32'd1);
    p = auto_p ? (clr ? 3'd0 : pcnt_m) : pos;
    e = (tok >= 4'd12);
    for (int b = 0; b < 4; b++) begin
      x.data = '0;
      bd     = '0;
      for (int k = 0; k < 2; k++) begin
        if (!e) x.data[k*16 +: 16] = exp_add(tok_m[tok][b*2+k], pos_m[p][b*2+k], 1'b1);
        if (push_b) bd[k*16 +: 16] = exp_add(tok_m[tok][b*2+k], pos_m[p][b*2+k], 1'b0);
      end
      x.last = (b == 3);
      x.err  = e;
      sb_a.push_back(x);
      if (push_b) sb_b.push_back(bd);
    end
    if (clr) pcnt_m = 3'd0;
    if (auto_p) pcnt_m = pcnt_m + 3'd1;
    es_a.in_valid  = 1'b1;
    es_a.token_id  = tok;
    es_a.pos_auto  = auto_p;
    es_a.position  = pos;
    es_a.seq_clear = clr;
    tick();
    es_a.in_valid  = 1'b0;
    es_a.seq_clear = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_beat, input int stall_len);
    int    beat;
    int    guard;
    beat_t x;
    beat  = 0;
    guard = 0;
    while (beat < n && guard < 200 && sb_a.size() > 0) begin
      if (es_a.out_valid) begin
        if (beat == stall_beat && stall_len > 0) begin
          es_a.out_ready = 1'b0;
          repeat (stall_len) begin
            tick();
            chk("stall_valid", {31'd0, es_a.out_valid}, 32'd1);
            chk("stall_data", es_a.out_data, sb_a[0].data);
            chk("stall_last", {31'd0, es_a.out_last}, {31'd0, sb_a[0].last});
            chk("stall_in_ready", {31'd0, es_a.in_ready}, 32'd0);
          end
          es_a.out_ready = 1'b1;
          stall_len = 0;
        end
        x = sb_a.pop_front();
        chk("beat_data", es_a.out_data, x.data);
        chk("beat_last", {31'd0, es_a.out_last}, {31'd0, x.last});
        chk("beat_err", {31'd0, es_a.out_err}, {31'd0, x.err});
        if (sb_b.size() > 0) chk("wrap_data", es_b.out_data, sb_b.pop_front());
        beat++;
      end
      tick();
      guard++;
    end
    chk("collect_done", beat, n);
  endtask

  initial begin
    rst = 1'b1;
    es_a.load_en = 1'b0; es_a.load_sel = 1'b0; es_a.load_row = '0; es_a.load_col = '0;
    es_a.load_data = '0; es_a.in_valid = 1'b0; es_a.token_id = '0; es_a.pos_auto = 1'b0;
    es_a.position = '0; es_a.seq_clear = 1'b0; es_a.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", {31'd0, es_a.out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, es_a.out_last}, 32'd0);
    chk("rst_out_err", {31'd0, es_a.out_err}, 32'd0);
    chk("rst_out_data", es_a.out_data, 32'd0);
    chk("rst_pos_cnt", {29'd0, es_a.pos_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, es_a.in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {31'd0, es_a.in_ready}, 32'd1);

    // Basic lookup with latency and a 5-cycle stall on the second beat.
    for (int c = 0; c < 8; c++) begin
      load(TBL_TOKEN, 3, c, 16'((c + 1) * 256));
      load(TBL_POS, 2, c, 16'h0080);
    end
    request(4'd3, 1'b0, 3'd2, 1'b0, 1'b0);
    chk("first_beat_const", sb_a[0].data, 32'h0280_0180);
    chk("read_cycle_valid", {31'd0, es_a.out_valid}, 32'd0);
    tick();
    chk("first_valid_t2", {31'd0, es_a.out_valid}, 32'd1);
    collect(4, 1, 5);

    // Saturating versus wrapping sums.
    load(TBL_TOKEN, 5, 0, 16'h7F00); load(TBL_POS, 3, 0, 16'h0200);
    load(TBL_TOKEN, 5, 1, 16'h8100); load(TBL_POS, 3, 1, 16'hFF00);
    load(TBL_TOKEN, 5, 2, 16'h8000); load(TBL_POS, 3, 2, 16'hFF00);
    for (int c = 3; c < 8; c++) begin
      load(TBL_TOKEN, 5, c, 16'h0000);
      load(TBL_POS, 3, c, 16'h0000);
    end
    request(4'd5, 1'b0, 3'd3, 1'b0, 1'b1);
    chk("sat_const", sb_a[0].data, {Q_MIN, Q_MAX});
    chk("wrap_const", sb_b[0], 32'h8000_8100);
    collect(4, -1, 0);

    // Auto-position sequence through the wrap.
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 8; c++)
        load(TBL_POS, p, c, 16'(p * 16 + c));
    for (int i = 0; i < 9; i++) begin
      request(4'd3, 1'b1, 3'd0, 1'b0, 1'b0);
      collect(4, -1, 0);
      chk("auto_pos_cnt", {29'd0, es_a.pos_cnt}, {29'd0, pcnt_m});
    end
    chk("pos_cnt_after_9", {29'd0, es_a.pos_cnt}, 32'd1);

    request(4'd3, 1'b1, 3'd0, 1'b1, 1'b0);
    collect(4, -1, 0);
    chk("clear_pos_cnt", {29'd0, es_a.pos_cnt}, 32'd1);

    // Out-of-range token still streams all beats and advances the counter.
    load(TBL_TOKEN, 13, 0, 16'h1234);
    request(4'd13, 1'b1, 3'd0, 1'b0, 1'b0);
    collect(4, -1, 0);
    chk("oor_pos_cnt", {29'd0, es_a.pos_cnt}, 32'd2);

    // Reset during the third beat.
    request(4'd3, 1'b0, 3'd2, 1'b0, 1'b0);
    collect(2, -1, 0);
    tick();
    chk("beat3_valid", {31'd0, es_a.out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, es_a.out_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, es_a.out_last}, 32'd0);
    chk("mid_rst_data", es_a.out_data, 32'd0);
    chk("mid_rst_pos_cnt", {29'd0, es_a.pos_cnt}, 32'd0);
    rst = 1'b0;
    sb_a.delete();
    pcnt_m = 3'd0;
    tick();
    chk("post_rst_in_ready", {31'd0, es_a.in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, es_a.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
